// File: rtl/reg_file_pkg.sv
// Shared definitions for the rename-tracking register file: index/tag widths,
// data width, boolean constants and the operand-source encoding.
package reg_file_pkg;

  localparam int REGID_W = 5;
  localparam int ROBID_W = 4;
  localparam int XLEN_W  = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_REG,
    SRC_COMMIT,
    SRC_ROB,
    SRC_WAIT
  } opnd_src_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One operand lookup: resolves a source register to a ready value or to the
// ROB tag of its producer, using the fixed zero/reg/commit/ROB priority.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int REG_W = REGID_W,
  parameter int ROB_W = ROBID_W,
  parameter int XLEN  = XLEN_W
) (
  input  logic [REG_W-1:0] rs,
  input  logic             busy,
  input  logic [XLEN-1:0]  value,
  input  logic [ROB_W-1:0] tag,
  input  logic             commit_sgn,
  input  logic [ROB_W-1:0] commit_rob_name,
  input  logic [XLEN-1:0]  commit_value,
  input  logic             rob_rdy,
  input  logic [XLEN-1:0]  rob_val,
  output logic             rdy,
  output logic [XLEN-1:0]  val,
  output logic [ROB_W-1:0] ord
);

  opnd_src_e src;

  always_comb begin
    src = SRC_WAIT;
    if (rs == '0)                                   src = SRC_ZERO;
    else if (!busy)                                 src = SRC_REG;
    // The ROB drops its ready bit on the commit cycle, so the commit bus must win.
    else if (commit_sgn && commit_rob_name == tag)  src = SRC_COMMIT;
    else if (rob_rdy)                               src = SRC_ROB;
  end

  always_comb begin
    rdy = True;
    val = '0;
    ord = tag;
    case (src)
      SRC_ZERO:   val = '0;
      SRC_REG:    val = value;
      SRC_COMMIT: val = commit_value;
      SRC_ROB:    val = rob_val;
      default:    rdy = False;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags, commit write-back and flush.
// Define REG_PERF_EN to add commit/flush event counters.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int REG_W   = REGID_W,
  parameter int ROB_W   = ROBID_W,
  parameter int XLEN    = XLEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [REG_W-1:0] is_rs1,
  input  logic [REG_W-1:0] is_rs2,
  output logic             is_rdy1,
  output logic             is_rdy2,
  output logic [XLEN-1:0]  is_val1,
  output logic [XLEN-1:0]  is_val2,
  output logic [ROB_W-1:0] is_ord1,
  output logic [ROB_W-1:0] is_ord2,
  input  logic             is_sgn,
  input  logic [REG_W-1:0] is_dest,
  input  logic [ROB_W-1:0] is_rob_name,
  output logic [ROB_W-1:0] rob_ord1,
  output logic [ROB_W-1:0] rob_ord2,
  input  logic             rob_rdy1,
  input  logic             rob_rdy2,
  input  logic [XLEN-1:0]  rob_val1,
  input  logic [XLEN-1:0]  rob_val2,
  input  logic             commit_sgn,
  input  logic [REG_W-1:0] commit_dest,
  input  logic [XLEN-1:0]  commit_value,
  input  logic [ROB_W-1:0] commit_rob_name,
`ifdef REG_PERF_EN
  output logic [31:0]      perf_commit_cnt,
  output logic [31:0]      perf_flush_cnt,
`endif
  input  logic             jp_wrong
);

  logic [XLEN-1:0]    value_q [REG_NUM];
  logic [XLEN-1:0]    value_d [REG_NUM];
  logic [ROB_W-1:0]   tag_q   [REG_NUM];
  logic [ROB_W-1:0]   tag_d   [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  logic commit_en;
  logic rename_en;
  logic rename_hits_commit;

  assign commit_en          = rdy && commit_sgn && (commit_dest != '0);
  assign rename_en          = rdy && is_sgn && (is_dest != '0) && !jp_wrong;
  assign rename_hits_commit = rename_en && (is_dest == commit_dest);

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (commit_en) begin
      value_d[commit_dest] = commit_value;
      // Only the newest producer may retire the rename; a same-cycle rename keeps it busy.
      if (tag_q[commit_dest] == commit_rob_name && !rename_hits_commit)
        busy_d[commit_dest] = False;
    end
    if (rdy && jp_wrong) begin
      busy_d = '0;
    end else if (rename_en) begin
      busy_d[is_dest] = True;
      tag_d[is_dest]  = is_rob_name;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '{default: '0};
      tag_q   <= '{default: '0};
      busy_q  <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  assign rob_ord1 = tag_q[is_rs1];
  assign rob_ord2 = tag_q[is_rs2];

  reg_file_rd_port #(.REG_W(REG_W), .ROB_W(ROB_W), .XLEN(XLEN)) u_rd_port1 (
    .rs              (is_rs1),
    .busy            (busy_q[is_rs1]),
    .value           (value_q[is_rs1]),
    .tag             (tag_q[is_rs1]),
    .commit_sgn      (commit_sgn),
    .commit_rob_name (commit_rob_name),
    .commit_value    (commit_value),
    .rob_rdy         (rob_rdy1),
    .rob_val         (rob_val1),
    .rdy             (is_rdy1),
    .val             (is_val1),
    .ord             (is_ord1)
  );

  reg_file_rd_port #(.REG_W(REG_W), .ROB_W(ROB_W), .XLEN(XLEN)) u_rd_port2 (
    .rs              (is_rs2),
    .busy            (busy_q[is_rs2]),
    .value           (value_q[is_rs2]),
    .tag             (tag_q[is_rs2]),
    .commit_sgn      (commit_sgn),
    .commit_rob_name (commit_rob_name),
    .commit_value    (commit_value),
    .rob_rdy         (rob_rdy2),
    .rob_val         (rob_val2),
    .rdy             (is_rdy2),
    .val             (is_val2),
    .ord             (is_ord2)
  );

`ifdef REG_PERF_EN
  logic [31:0] perf_commit_cnt_q, perf_commit_cnt_d;
  logic [31:0] perf_flush_cnt_q,  perf_flush_cnt_d;

  // Commits to x0 are still counted: the counter tracks ROB retirement, not writes.
  always_comb begin
    perf_commit_cnt_d = perf_commit_cnt_q;
    perf_flush_cnt_d  = perf_flush_cnt_q;
    if (rdy && commit_sgn) perf_commit_cnt_d = perf_commit_cnt_q + 32'd1;
    if (rdy && jp_wrong)   perf_flush_cnt_d  = perf_flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_commit_cnt_q <= '0;
      perf_flush_cnt_q  <= '0;
    end else begin
      perf_commit_cnt_q <= perf_commit_cnt_d;
      perf_flush_cnt_q  <= perf_flush_cnt_d;
    end
  end

  assign perf_commit_cnt = perf_commit_cnt_q;
  assign perf_flush_cnt  = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [4:0]  is_rs1 = '0, is_rs2 = '0;
  logic        is_rdy1, is_rdy2;
  logic [31:0] is_val1, is_val2;
  logic [3:0]  is_ord1, is_ord2;
  logic        is_sgn = 1'b0;
  logic [4:0]  is_dest = '0;
  logic [3:0]  is_rob_name = '0;
  logic [3:0]  rob_ord1, rob_ord2;
  logic        rob_rdy1 = 1'b0, rob_rdy2 = 1'b0;
  logic [31:0] rob_val1 = '0, rob_val2 = '0;
  logic        commit_sgn = 1'b0;
  logic [4:0]  commit_dest = '0;
  logic [31:0] commit_value = '0;
  logic [3:0]  commit_rob_name = '0;
  logic        jp_wrong = 1'b0;
`ifdef REG_PERF_EN
  logic [31:0] perf_commit_cnt, perf_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];
  int unsigned m_commits = 0;
  int unsigned m_flushes = 0;

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_rs1(is_rs1), .is_rs2(is_rs2),
    .is_rdy1(is_rdy1), .is_rdy2(is_rdy2),
    .is_val1(is_val1), .is_val2(is_val2),
    .is_ord1(is_ord1), .is_ord2(is_ord2),
    .is_sgn(is_sgn), .is_dest(is_dest), .is_rob_name(is_rob_name),
    .rob_ord1(rob_ord1), .rob_ord2(rob_ord2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
    .rob_val1(rob_val1), .rob_val2(rob_val2),
    .commit_sgn(commit_sgn), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_rob_name(commit_rob_name),
`ifdef REG_PERF_EN
    .perf_commit_cnt(perf_commit_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .jp_wrong(jp_wrong)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
    end
    m_commits = 0; m_flushes = 0;
  endfunction

  // Apply one accepted clock edge of architectural effects.
  function automatic void model_update();
    int cd, id;
    cd = int'(commit_dest);
    id = int'(is_dest);
    if (!rdy) return;
    if (commit_sgn) m_commits++;
    if (jp_wrong) m_flushes++;
    if (commit_sgn && cd != 0) begin
      m_val[cd] = commit_value;
      if (m_tag[cd] == commit_rob_name && !(is_sgn && id == cd && !jp_wrong))
        m_busy[cd] = 0;
    end
    if (jp_wrong) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (is_sgn && id != 0) begin
      m_busy[id] = 1;
      m_tag[id]  = is_rob_name;
    end
  endfunction

  function automatic void model_read(input int rs, input bit rrdy, input logic [31:0] rval,
                                     output bit erdy, output logic [31:0] evalue);
    erdy = 1; evalue = '0;
    if (rs == 0) evalue = '0;
    else if (!m_busy[rs]) evalue = m_val[rs];
    else if (commit_sgn && commit_rob_name == m_tag[rs]) evalue = commit_value;
    else if (rrdy) evalue = rval;
    else erdy = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic clear_strobes();
    is_sgn = 0; commit_sgn = 0; jp_wrong = 0; rob_rdy1 = 0; rob_rdy2 = 0;
  endtask

  task automatic issue(input logic [4:0] d, input logic [3:0] t);
    is_sgn = 1; is_dest = d; is_rob_name = t;
    tick();
    is_sgn = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    is_rs1 = 5; is_rs2 = 0;
    #1;
    n_tests++;
    if (is_rdy1 !== 1'b1 || is_val1 !== 32'd0 || is_ord1 !== 4'd0 || rob_ord1 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_port1: rdy=%b val=%h ord=%h rob_ord=%h expected 1/0/0/0", is_rdy1, is_val1, is_ord1, rob_ord1);
    end
    n_tests++;
    if (is_rdy2 !== 1'b1 || is_val2 !== 32'd0 || is_ord2 !== 4'd0 || rob_ord2 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_port2: rdy=%b val=%h ord=%h rob_ord=%h expected 1/0/0/0", is_rdy2, is_val2, is_ord2, rob_ord2);
    end
`ifdef REG_PERF_EN
    n_tests++;
    if (perf_commit_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: commit=%0d flush=%0d expected 0/0", perf_commit_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_rename_stall();
    issue(5'd3, 4'd7);
    is_rs1 = 3; rob_rdy1 = 0;
    #1;
    n_tests++;
    if (is_rdy1 !== 1'b0 || is_ord1 !== 4'd7 || rob_ord1 !== 4'd7) begin
      n_fail++;
      $display("FAIL rename_stall: rdy=%b ord=%h rob_ord=%h expected 0/7/7", is_rdy1, is_ord1, rob_ord1);
    end
    rob_rdy1 = 1; rob_val1 = 32'h55;
    #1;
    n_tests++;
    if (is_rdy1 !== 1'b1 || is_val1 !== 32'h55) begin
      n_fail++;
      $display("FAIL rename_rob_fwd: rdy=%b val=%h expected 1/00000055", is_rdy1, is_val1);
    end
    rob_rdy1 = 0;
  endtask

  task automatic test_commit_bypass();
    is_rs1 = 3; rob_rdy1 = 0;
    commit_sgn = 1; commit_dest = 3; commit_value = 32'hABCD; commit_rob_name = 7;
    #1;
    n_tests++;
    if (is_rdy1 !== 1'b1 || is_val1 !== 32'hABCD) begin
      n_fail++;
      $display("FAIL commit_bypass: rdy=%b val=%h expected 1/0000abcd", is_rdy1, is_val1);
    end
    tick();
    commit_sgn = 0;
    #1;
    n_tests++;
    if (is_rdy1 !== 1'b1 || is_val1 !== 32'hABCD) begin
      n_fail++;
      $display("FAIL commit_retire: rdy=%b val=%h expected 1/0000abcd", is_rdy1, is_val1);
    end
  endtask

  task automatic test_stale_commit();
    issue(5'd4, 4'd2);
    issue(5'd4, 4'd5);
    commit_sgn = 1; commit_dest = 4; commit_value = 32'd9; commit_rob_name = 2;
    tick();
    commit_sgn = 0;
    is_rs1 = 4; rob_rdy1 = 0;
    #1;
    n_tests++;
    if (is_rdy1 !== 1'b0 || is_ord1 !== 4'd5) begin
      n_fail++;
      $display("FAIL stale_commit: rdy=%b ord=%h expected 0/5", is_rdy1, is_ord1);
    end
  endtask

  task automatic test_same_cycle();
    issue(5'd6, 4'd1);
    commit_sgn = 1; commit_dest = 6; commit_value = 32'h66; commit_rob_name = 1;
    is_sgn = 1; is_dest = 6; is_rob_name = 8;
    tick();
    clear_strobes();
    is_rs2 = 6;
    #1;
    n_tests++;
    if (is_rdy2 !== 1'b0 || is_ord2 !== 4'd8 || rob_ord2 !== 4'd8) begin
      n_fail++;
      $display("FAIL same_cycle: rdy=%b ord=%h rob_ord=%h expected 0/8/8", is_rdy2, is_ord2, rob_ord2);
    end
  endtask

  task automatic test_flush();
    logic [4:0]  regs [6];
    logic [31:0] expv [6];
    regs = '{5'd1, 5'd2, 5'd31, 5'd10, 5'd4, 5'd6};
    expv = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'h66};
    issue(5'd1, 4'd3);
    issue(5'd2, 4'd4);
    issue(5'd31, 4'd5);
    jp_wrong = 1; is_sgn = 1; is_dest = 10; is_rob_name = 9;
    tick();
    clear_strobes();
    for (int i = 0; i < 6; i++) begin
      is_rs1 = regs[i];
      #1;
      n_tests++;
      if (is_rdy1 !== 1'b1 || is_val1 !== expv[i]) begin
        n_fail++;
        $display("FAIL flush_x%0d: rdy=%b val=%h expected 1/%h", regs[i], is_rdy1, is_val1, expv[i]);
      end
    end
`ifdef REG_PERF_EN
    n_tests++;
    if (perf_flush_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL flush_perf: got %0d expected 1", perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_rdy_low();
    rdy = 0;
    is_sgn = 1; is_dest = 7; is_rob_name = 3;
    commit_sgn = 1; commit_dest = 3; commit_value = 32'h77; commit_rob_name = 0;
    tick();
    clear_strobes();
    rdy = 1;
    is_rs1 = 7; is_rs2 = 3;
    #1;
    n_tests++;
    if (is_rdy1 !== 1'b1 || is_val1 !== 32'd0 || is_rdy2 !== 1'b1 || is_val2 !== 32'hABCD) begin
      n_fail++;
      $display("FAIL rdy_low_freeze: x7 rdy=%b val=%h x3 rdy=%b val=%h expected 1/0 1/abcd",
               is_rdy1, is_val1, is_rdy2, is_val2);
    end
  endtask

  task automatic test_random();
    bit          e_rdy1, e_rdy2;
    logic [31:0] e_val1, e_val2;
    int          cd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      is_sgn      = $urandom_range(0, 1);
      is_dest     = 5'($urandom_range(0, 31));
      is_rob_name = 4'($urandom);
      jp_wrong    = ($urandom_range(0, 24) == 0);
      commit_sgn  = $urandom_range(0, 1);
      cd          = $urandom_range(0, 31);
      commit_dest = 5'(cd);
      commit_value = $urandom;
      commit_rob_name = $urandom_range(0, 1) ? m_tag[cd] : 4'($urandom);
      is_rs1 = 5'($urandom_range(0, 31));
      is_rs2 = ($urandom_range(0, 3) == 0) ? is_dest : 5'($urandom_range(0, 31));
      rob_rdy1 = $urandom_range(0, 1); rob_val1 = $urandom;
      rob_rdy2 = $urandom_range(0, 1); rob_val2 = $urandom;
      #1;
      model_read(int'(is_rs1), rob_rdy1, rob_val1, e_rdy1, e_val1);
      model_read(int'(is_rs2), rob_rdy2, rob_val2, e_rdy2, e_val2);
      n_tests++;
      if (is_rdy1 !== e_rdy1 || (e_rdy1 && is_val1 !== e_val1) ||
          is_ord1 !== m_tag[is_rs1] || rob_ord1 !== m_tag[is_rs1]) begin
        n_fail++;
        $display("FAIL random_port1 cyc%0d rs=%0d: rdy=%b val=%h ord=%h rob_ord=%h expected %b/%h/%h",
                 cyc, is_rs1, is_rdy1, is_val1, is_ord1, rob_ord1, e_rdy1, e_val1, m_tag[is_rs1]);
      end
      n_tests++;
      if (is_rdy2 !== e_rdy2 || (e_rdy2 && is_val2 !== e_val2) ||
          is_ord2 !== m_tag[is_rs2] || rob_ord2 !== m_tag[is_rs2]) begin
        n_fail++;
        $display("FAIL random_port2 cyc%0d rs=%0d: rdy=%b val=%h ord=%h rob_ord=%h expected %b/%h/%h",
                 cyc, is_rs2, is_rdy2, is_val2, is_ord2, rob_ord2, e_rdy2, e_val2, m_tag[is_rs2]);
      end
      tick();
    end
    clear_strobes();
    rdy = 1;
`ifdef REG_PERF_EN
    n_tests++;
    if (perf_commit_cnt !== m_commits || perf_flush_cnt !== m_flushes) begin
      n_fail++;
      $display("FAIL random_perf: commit=%0d flush=%0d expected %0d/%0d",
               perf_commit_cnt, perf_flush_cnt, m_commits, m_flushes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rename_stall();
    test_commit_bypass();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_rdy_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
